// File: rtl/cam_access_pkg.sv
// Shared types for the CAM access controller: write FSM states, the
// lookup response record and a saturating counter helper.
package cam_access_pkg;

  // Widest CAM address a response can carry; narrower addresses are
  // zero-extended into this field.
  localparam int CAM_RSP_ADDR_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic                          hit;
    logic [CAM_RSP_ADDR_MAX_W-1:0] addr;
  } cam_rsp_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cam_access_ctrl_fifo.sv
// Response FIFO (cam_rsp_fifo): small circular buffer holding lookup
// results until the consumer takes them. Callers guarantee no push when full.
module cam_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_do_pop = i_pop && (r_count != '0);
  assign o_valid  = (r_count != '0);
  assign o_data   = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      if (i_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/cam_access_ctrl.sv
// CAM access controller: arbitrates single writes against pipelined,
// credit-limited lookups and returns lookup results in request order.
// Optional event counters are built when CAM_ACCESS_STATS_EN is defined.
module cam_access_ctrl
  import cam_access_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int LOOKUP_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_wr_req_valid,
  output logic                  o_wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_req_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_req_data,
  input  logic                  i_lu_req_valid,
  output logic                  o_lu_req_ready,
  input  logic [DATA_WIDTH-1:0] i_lu_req_key,
  output logic                  o_lu_rsp_valid,
  input  logic                  i_lu_rsp_ready,
  output logic                  o_lu_rsp_hit,
  output logic [ADDR_WIDTH-1:0] o_lu_rsp_addr,
  output logic                  o_cam_we,
  output logic [ADDR_WIDTH-1:0] o_cam_wr_addr,
  output logic [DATA_WIDTH-1:0] o_cam_din,
  input  logic                  i_cam_busy,
  output logic [DATA_WIDTH-1:0] o_cam_cmp_din,
  input  logic                  i_cam_match,
  input  logic [ADDR_WIDTH-1:0] i_cam_match_addr,
  output logic [31:0]           o_stat_hits,
  output logic [31:0]           o_stat_misses,
  output logic [31:0]           o_stat_writes
);

  localparam int CREDITS = LOOKUP_LATENCY + 1;
  localparam int CRW     = $clog2(CREDITS + 1);

  wr_state_e                 r_state;
  wr_state_e                 w_state_next;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic [DATA_WIDTH-1:0]     r_wr_data;
  logic                      r_active;
  logic [CRW-1:0]            r_credits;
  logic                      r_cmp_valid;
  logic [DATA_WIDTH-1:0]     r_cmp_din;
  logic [LOOKUP_LATENCY-1:0] r_tag;
  logic                      r_cap_valid;
  cam_rsp_t                  r_cap;
  cam_rsp_t                  w_rsp;
  logic                      w_fifo_valid;
  logic                      w_inflight;
  logic                      w_wr_accept;
  logic                      w_cam_we;
  logic                      w_lu_req_ready;
  logic                      w_lu_accept;
  logic                      w_pop;

  // Any lookup still between key issue and result capture blocks a CAM write
  assign w_inflight     = r_cmp_valid || (|r_tag) || r_cap_valid;
  assign w_lu_req_ready = r_active && (r_state == IDLE) && !i_wr_req_valid &&
                          !i_cam_busy && (r_credits != '0);
  assign w_lu_accept    = i_lu_req_valid && w_lu_req_ready;
  assign w_pop          = w_fifo_valid && i_lu_rsp_ready;

  assign o_wr_req_ready = w_wr_accept;
  assign o_lu_req_ready = w_lu_req_ready;
  assign o_cam_we       = w_cam_we;
  assign o_cam_wr_addr  = r_wr_addr;
  assign o_cam_din      = r_wr_data;
  assign o_cam_cmp_din  = r_cmp_din;
  assign o_lu_rsp_valid = w_fifo_valid;
  assign o_lu_rsp_hit   = w_fifo_valid && w_rsp.hit;
  assign o_lu_rsp_addr  = w_fifo_valid ? w_rsp.addr[ADDR_WIDTH-1:0] : '0;

  if (ADDR_WIDTH < CAM_RSP_ADDR_MAX_W) begin : g_addr_pad
    logic [CAM_RSP_ADDR_MAX_W-ADDR_WIDTH-1:0] w_unused_addr_hi;
    assign w_unused_addr_hi = w_rsp.addr[CAM_RSP_ADDR_MAX_W-1:ADDR_WIDTH];
  end

  // Readies stay low while in reset and until the first clock after release
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_active <= 1'b0;
    else           r_active <= 1'b1;
  end

  // Write FSM state and the write request captured on acceptance
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= IDLE;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_accept) begin
        r_wr_addr <= i_wr_req_addr;
        r_wr_data <= i_wr_req_data;
      end
    end
  end

  // Write FSM next state: accept only with the lookup pipe drained and CAM idle
  always_comb begin
    w_state_next = r_state;
    w_wr_accept  = 1'b0;
    w_cam_we     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_active && i_wr_req_valid && !w_inflight && !i_cam_busy) begin
          w_wr_accept  = 1'b1;
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_cam_we     = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (!i_cam_busy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Response credits: one taken per accepted lookup, one returned per popped response
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_credits <= CRW'(CREDITS);
    end else if (w_lu_accept && !w_pop) begin
      r_credits <= r_credits - CRW'(1);
    end else if (!w_lu_accept && w_pop) begin
      r_credits <= r_credits + CRW'(1);
    end
  end

  // Lookup pipe: key issue, LOOKUP_LATENCY tag stages, then result capture
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cmp_valid <= 1'b0;
      r_cmp_din   <= '0;
      r_tag       <= '0;
      r_cap_valid <= 1'b0;
      r_cap       <= '0;
    end else begin
      r_cmp_valid <= w_lu_accept;
      if (w_lu_accept) r_cmp_din <= i_lu_req_key;
      r_tag[0] <= r_cmp_valid;
      for (int i = 1; i < LOOKUP_LATENCY; i++) r_tag[i] <= r_tag[i-1];
      r_cap_valid <= r_tag[LOOKUP_LATENCY-1];
      if (r_tag[LOOKUP_LATENCY-1]) begin
        r_cap.hit  <= i_cam_match;
        r_cap.addr <= i_cam_match ? CAM_RSP_ADDR_MAX_W'(i_cam_match_addr) : '0;
      end
    end
  end

  cam_rsp_fifo #(
    .DEPTH (CREDITS),
    .WIDTH ($bits(cam_rsp_t))
  ) u_rsp_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_push   (r_cap_valid),
    .i_data   (r_cap),
    .i_pop    (w_pop),
    .o_valid  (w_fifo_valid),
    .o_data   (w_rsp)
  );

`ifdef CAM_ACCESS_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;
  logic [31:0] r_writes;

  // Saturating event counters: responses by outcome and CAM write pulses
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_writes <= '0;
    end else begin
      if (r_cap_valid && r_cap.hit)  r_hits   <= sat_inc(r_hits);
      if (r_cap_valid && !r_cap.hit) r_misses <= sat_inc(r_misses);
      if (w_cam_we)                  r_writes <= sat_inc(r_writes);
    end
  end

  assign o_stat_hits   = r_hits;
  assign o_stat_misses = r_misses;
  assign o_stat_writes = r_writes;
`else
  assign o_stat_hits   = '0;
  assign o_stat_misses = '0;
  assign o_stat_writes = '0;
`endif

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Self-checking bench for cam_access_ctrl: directed writes and lookups
// against a behavioural CAM, with a response scoreboard.
module tb_cam_access_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;
`ifdef CAM_ACCESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] addr;
  } expRsp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wrReqValid, wrReqReady;
  logic [AW-1:0] wrReqAddr;
  logic [DW-1:0] wrReqData;
  logic          luReqValid, luReqReady;
  logic [DW-1:0] luReqKey;
  logic          luRspValid, luRspReady, luRspHit;
  logic [AW-1:0] luRspAddr;
  logic          camWe;
  logic [AW-1:0] camWrAddr;
  logic [DW-1:0] camDin;
  logic          camBusy;
  logic [DW-1:0] camCmpDin;
  logic          camMatch;
  logic [AW-1:0] camMatchAddr;
  logic [31:0]   statHits, statMisses, statWrites;

  expRsp_t       expQ[$];
  int            total = 0;
  int            bad = 0;
  int            cycle = 0;
  int            luAccepts = 0;
  int            lastLuCycle = 0;
  int            lastWrCycle = 0;
  int            wrReadyPulses = 0;
  int            weCycles = 0;

  logic [DW-1:0] camMem [16];
  bit            camVld [16];
  logic          pendHit = 1'b0;
  logic [AW-1:0] pendAddr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  cam_access_ctrl #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .LOOKUP_LATENCY (1)
  ) dut (
    .i_clk            (clk),
    .i_resetn         (resetn),
    .i_wr_req_valid   (wrReqValid),
    .o_wr_req_ready   (wrReqReady),
    .i_wr_req_addr    (wrReqAddr),
    .i_wr_req_data    (wrReqData),
    .i_lu_req_valid   (luReqValid),
    .o_lu_req_ready   (luReqReady),
    .i_lu_req_key     (luReqKey),
    .o_lu_rsp_valid   (luRspValid),
    .i_lu_rsp_ready   (luRspReady),
    .o_lu_rsp_hit     (luRspHit),
    .o_lu_rsp_addr    (luRspAddr),
    .o_cam_we         (camWe),
    .o_cam_wr_addr    (camWrAddr),
    .o_cam_din        (camDin),
    .i_cam_busy       (camBusy),
    .o_cam_cmp_din    (camCmpDin),
    .i_cam_match      (camMatch),
    .i_cam_match_addr (camMatchAddr),
    .o_stat_hits      (statHits),
    .o_stat_misses    (statMisses),
    .o_stat_writes    (statWrites)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Behavioural CAM: stores on write pulses, answers a compare one cycle later
  always @(negedge clk) begin
    if (camWe) begin
      camMem[camWrAddr] = camDin;
      camVld[camWrAddr] = 1'b1;
    end
    pendHit  = 1'b0;
    pendAddr = '0;
    for (int a = 0; a < 16; a++) begin
      if (!pendHit && camVld[a] && camMem[a] == camCmpDin) begin
        pendHit  = 1'b1;
        pendAddr = 4'(a);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    camMatch     = pendHit;
    camMatchAddr = pendAddr;
  end

  // Monitor: event counts and scoreboard comparison of every transferred response
  always @(negedge clk) begin
    if (resetn) begin
      if (wrReqReady) wrReadyPulses++;
      if (camWe) weCycles++;
      if (luRspValid && luRspReady) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rsp_unexpected: got hit=%0b addr=%0d, required no response", luRspHit, luRspAddr);
        end else begin
          expRsp_t e;
          e = expQ.pop_front();
          checkOutput("rsp_hit", 32'(luRspHit), 32'(e.hit));
          checkOutput("rsp_addr", 32'(luRspAddr), 32'(e.addr));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] key, input logic expHit, input logic [AW-1:0] expAddr);
    bit got = 1'b0;
    luReqValid = 1'b1;
    luReqKey   = key;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (luReqReady) begin
        got = 1'b1;
        @(posedge clk);
        expQ.push_back('{hit: expHit, addr: expAddr});
        luAccepts++;
        #1;
        lastLuCycle = cycle;
      end
    end
    luReqValid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL lu_accept_timeout: key 0x%0h not accepted within 200 cycles", key);
    end
  endtask

  task automatic applyWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit got = 1'b0;
    wrReqValid = 1'b1;
    wrReqAddr  = addr;
    wrReqData  = data;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (wrReqReady) begin
        got = 1'b1;
        @(posedge clk);
        #1;
        lastWrCycle = cycle;
      end
    end
    wrReqValid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL wr_accept_timeout: addr %0d not accepted within 200 cycles", addr);
    end else begin
      @(negedge clk);
      checkOutput("cam_we", 32'(camWe), 32'd1);
      checkOutput("cam_wr_addr", 32'(camWrAddr), 32'(addr));
      checkOutput("cam_din", 32'(camDin), 32'(data));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_ready"}, 32'(wrReqReady), 32'd0);
    checkOutput({tag, "_lu_ready"}, 32'(luReqReady), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(luRspValid), 32'd0);
    checkOutput({tag, "_rsp_hit"}, 32'(luRspHit), 32'd0);
    checkOutput({tag, "_rsp_addr"}, 32'(luRspAddr), 32'd0);
    checkOutput({tag, "_cam_we"}, 32'(camWe), 32'd0);
    checkOutput({tag, "_cam_wr_addr"}, 32'(camWrAddr), 32'd0);
    checkOutput({tag, "_cam_din"}, 32'(camDin), 32'd0);
    checkOutput({tag, "_cmp_din"}, 32'(camCmpDin), 32'd0);
    checkOutput({tag, "_stat_hits"}, statHits, 32'd0);
    checkOutput({tag, "_stat_misses"}, statMisses, 32'd0);
    checkOutput({tag, "_stat_writes"}, statWrites, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    int acceptBase;
    bit sawValid;
    for (int a = 0; a < 16; a++) begin
      camVld[a] = 1'b0;
      camMem[a] = '0;
    end
    resetn = 1'b0; wrReqValid = 1'b0; wrReqAddr = '0; wrReqData = '0;
    luReqValid = 1'b0; luReqKey = '0; luRspReady = 1'b1; camBusy = 1'b0;
    camMatch = 1'b0; camMatchAddr = '0;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] write 3/0xBEEF with 16 busy cycles");
    applyWrite(4'd3, 16'hBEEF);
    @(posedge clk);
    #1 camBusy = 1'b1;
    repeat (16) begin
      @(negedge clk);
      checkOutput("lu_ready_while_busy", 32'(luReqReady), 32'd0);
    end
    @(posedge clk);
    #1 camBusy = 1'b0;
    @(negedge clk);
    checkOutput("lu_ready_wait_exit", 32'(luReqReady), 32'd0);
    @(negedge clk);
    checkOutput("lu_ready_after_busy", 32'(luReqReady), 32'd1);
    checkOutput("wr_ready_pulses", 32'(wrReadyPulses), 32'd1);
    checkOutput("cam_we_cycles", 32'(weCycles), 32'd1);

    $display("[TB] lookup hit and miss");
    @(posedge clk);
    #1;
    applyStimulus(16'hBEEF, 1'b1, 4'd3);
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (luRspValid) break;
      lat++;
    end
    checkOutput("lookup_latency", 32'(lat), 32'd3);
    @(posedge clk);
    #1;
    applyStimulus(16'h1234, 1'b0, 4'd0);
    repeat (8) @(negedge clk);
    checkOutput("stat_hits", statHits, STATS ? 32'd1 : 32'd0);
    checkOutput("stat_misses", statMisses, STATS ? 32'd1 : 32'd0);
    checkOutput("stat_writes", statWrites, STATS ? 32'd1 : 32'd0);

    @(posedge clk);
    #1;
    applyWrite(4'd5, 16'h5555);
    applyWrite(4'd9, 16'h0909);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] eight lookups with response back-pressure");
    luRspReady = 1'b0;
    acceptBase = luAccepts;
    fork
      begin
        applyStimulus(16'hBEEF, 1'b1, 4'd3);
        applyStimulus(16'h5555, 1'b1, 4'd5);
        applyStimulus(16'h1234, 1'b0, 4'd0);
        applyStimulus(16'h0909, 1'b1, 4'd9);
        applyStimulus(16'hBEEF, 1'b1, 4'd3);
        applyStimulus(16'h0000, 1'b0, 4'd0);
        applyStimulus(16'h0909, 1'b1, 4'd9);
        applyStimulus(16'h5555, 1'b1, 4'd5);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("accepts_under_backpressure", 32'(luAccepts - acceptBase), 32'd2);
        checkOutput("lu_ready_no_credit", 32'(luReqReady), 32'd0);
        @(posedge clk);
        #1 luRspReady = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    checkOutput("burst_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] write raised with two lookups in flight");
    applyStimulus(16'hBEEF, 1'b1, 4'd3);
    applyStimulus(16'h7777, 1'b0, 4'd0);
    applyWrite(4'd7, 16'h7777);
    checkOutput("write_waits_for_drain", 32'(lastWrCycle - lastLuCycle), 32'd4);
    applyStimulus(16'h7777, 1'b1, 4'd7);
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] reset during WAIT with a response pending");
    luRspReady = 1'b0;
    applyStimulus(16'h5555, 1'b1, 4'd5);
    repeat (5) @(posedge clk);
    #1;
    applyWrite(4'd12, 16'hCCCC);
    @(posedge clk);
    #1 camBusy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkResetOutputs("midreset");
    camBusy = 1'b0;
    luRspReady = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (luRspValid) sawValid = 1'b1;
    end
    checkOutput("no_rsp_after_reset", 32'(sawValid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(16'h5555, 1'b1, 4'd5);
    applyStimulus(16'hCCCC, 1'b1, 4'd12);
    applyStimulus(16'h0909, 1'b1, 4'd9);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("final_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_access_ctrl.md
CAM_ACCESS_CTRL -- requirements
Module: cam_access_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, CAM address width.
REQ-002 Parameter DATA_WIDTH, default 16, CAM entry/key width.
REQ-003 Parameter LOOKUP_LATENCY, default 1, cycles from CAM_CMP_DIN driven to CAM_MATCH valid; range 1-4.
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RESETN  in  1  asynchronous, active-low reset.
REQ-006 WR_REQ_VALID/WR_REQ_READY  in/out  1  write request handshake.
REQ-007 WR_REQ_ADDR  in  ADDR_WIDTH; WR_REQ_DATA  in  DATA_WIDTH  entry to store.
REQ-008 LU_REQ_VALID/LU_REQ_READY  in/out  1; LU_REQ_KEY  in  DATA_WIDTH  lookup key.
REQ-009 LU_RSP_VALID/LU_RSP_READY  out/in  1; LU_RSP_HIT  out  1; LU_RSP_ADDR  out  ADDR_WIDTH.
REQ-010 CAM_WE  out  1; CAM_WR_ADDR  out  ADDR_WIDTH; CAM_DIN  out  DATA_WIDTH; CAM_BUSY  in  1.
REQ-011 CAM_CMP_DIN  out  DATA_WIDTH; CAM_MATCH  in  1; CAM_MATCH_ADDR  in  ADDR_WIDTH.
REQ-012 STAT_HITS, STAT_MISSES, STAT_WRITES  out  32 each  event counters.

Function
REQ-013 Handshake transfers when VALID and READY high on same edge; VALID never depends on READY.
REQ-014 Write FSM states IDLE, WRITE, WAIT; reset state IDLE.
REQ-015 IDLE->WRITE when WR_REQ_VALID, zero lookups in flight, CAM_BUSY low; WR_REQ_READY high for that one cycle only; addr/data registered.
REQ-016 WRITE: CAM_WE high exactly one cycle with registered addr/data; always ->WAIT.
REQ-017 WAIT: minimum one cycle; ->IDLE on first cycle CAM_BUSY is low.
REQ-018 Writes take priority: LU_REQ_READY low whenever WR_REQ_VALID high or FSM not IDLE or CAM_BUSY high.
REQ-019 Lookup accepted only with a free response credit; credits = LOOKUP_LATENCY+1 = response FIFO depth.
REQ-020 Accepted key drives CAM_CMP_DIN next cycle; a valid-tag shift register of LOOKUP_LATENCY stages marks when CAM_MATCH/CAM_MATCH_ADDR are captured.
REQ-021 Captured result pushed into response FIFO; LU_RSP_HIT=CAM_MATCH; LU_RSP_ADDR=CAM_MATCH_ADDR on hit, zero on miss.
REQ-022 Back-to-back lookups: one per cycle sustained while LU_RSP_READY high; responses in request order.
REQ-023 LU_RSP_READY low: FIFO fills, credits reach zero, LU_REQ_READY drops; no result lost or duplicated.
REQ-024 Simultaneous FIFO push and pop: occupancy unchanged; credit returned on pop.
REQ-025 Combined access latency, request accept to LU_RSP_VALID: LOOKUP_LATENCY+2 cycles with empty FIFO.

Reset
REQ-026 RESETN low: FSM IDLE, FIFO empty, tags cleared, credits full, counters zero.
REQ-027 Reset outputs: all READY/VALID, CAM_WE, LU_RSP_HIT low; all address/data outputs zero.
REQ-028 Reset mid-write or mid-lookup abandons the operation; no response emitted after release.

Configuration
REQ-029 Macro CAM_ACCESS_STATS_EN defined: STAT_HITS/STAT_MISSES increment per response pushed, STAT_WRITES per CAM_WE pulse; saturate at 2^32-1.
REQ-030 Macro undefined: counters not built; STAT_* outputs tied to zero; ports remain.

Structure
REQ-031 Shared package cam_access_pkg holds write-FSM state enum and response struct (hit, addr).
REQ-032 Response FIFO is one sub-module, cam_rsp_fifo, parameterised on depth and width.

Verification
REQ-033 Write addr 3, data 0xBEEF, CAM_BUSY high 16 cycles -> CAM_WE one cycle with 3/0xBEEF; WR_REQ_READY single pulse; LU_REQ_READY low until BUSY falls.
REQ-034 Lookup key 0xBEEF after that write -> LU_RSP_HIT=1, LU_RSP_ADDR=3 at accept+3 cycles (latency 1).
REQ-035 Lookup key 0x1234 with CAM_MATCH low -> HIT=0, ADDR=0; STAT_MISSES=1 with macro, 0 without.
REQ-036 8 back-to-back lookups, LU_RSP_READY held low 5 cycles -> LU_REQ_READY drops after 2 accepts; all 8 responses in order, none lost.
REQ-037 WR_REQ_VALID raised while 2 lookups in flight -> write waits for drain; CAM_WE never overlaps a pending tag.
REQ-038 RESETN pulsed low during WAIT with lookup in flight -> all outputs reset values; no LU_RSP_VALID after release.
